// File: rtl/cp0_exc_ctrl_pkg.sv
// Shared definitions for the CP0 exception/interrupt controller: register
// numbers, exception codes, the handler entry address and the SR write mask.
package cp0_exc_ctrl_pkg;

  // Handler address taken on every redirect; used by the NPC mux and the bench.
  localparam logic [31:0] EXC_ENTRY = 32'h0000_4180;

  // CP0 register numbers as seen by mtc0/mfc0.
  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_SR      = 5'd12;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_EPC     = 5'd14;

  // Implemented SR bits: IM[15:10], EXL[1], IE[0].
  localparam logic [31:0] SR_WMASK = 32'h0000_FC03;

  // Cause.ExcCode values.
  typedef enum logic [4:0] {
    EXC_INT     = 5'd0,
    EXC_ADEL    = 5'd4,
    EXC_ADES    = 5'd5,
    EXC_SYSCALL = 5'd8,
    EXC_RI      = 5'd10,
    EXC_OV      = 5'd12
  } exc_code_e;

endpackage

// File: rtl/cp0_exc_ctrl_if.sv
// M-stage <-> CP0 signal bundle. The pipeline is the master (drives mtc0,
// the M-stage instruction info and the interrupt lines); CP0 is the slave.
interface cp0_exc_ctrl_if;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [31:0] m_pc;
  logic        m_bd;
  logic [4:0]  m_exc_code;
  logic        m_eret;
  logic [5:0]  hw_int;
  logic        req;
  logic [31:0] epc_out;

  modport master (
    output we, addr, wdata, m_pc, m_bd, m_exc_code, m_eret, hw_int,
    input  rdata, req, epc_out
  );

  modport slave (
    input  we, addr, wdata, m_pc, m_bd, m_exc_code, m_eret, hw_int,
    output rdata, req, epc_out
  );
endinterface

// File: rtl/cp0_exc_ctrl_timer.sv
// Count/Compare timer for CP0 (only instantiated when CP0_TIMER_EN is defined).
// Count free-runs and wraps; a match with a non-zero Compare latches a sticky
// pending bit that only a Compare write clears. The match itself is also
// reported combinationally so the interrupt can be taken while Count==Compare.
module cp0_timer
  import cp0_exc_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        timer_irq
);

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        pend_q, pend_d;
  logic        match;

  assign match     = (count_q == compare_q) && (compare_q != 32'd0);
  assign timer_irq = pend_q | match;
  assign count     = count_q;
  assign compare   = compare_q;

  // Next-state: increment Count unless overwritten, track the sticky match.
  always_comb begin
    count_d   = count_q + 32'd1;
    compare_d = compare_q;
    pend_d    = pend_q | match;
    if (wr_en && addr == CP0_COUNT) begin
      count_d = wdata;
    end
    if (wr_en && addr == CP0_COMPARE) begin
      compare_d = wdata;
      pend_d    = 1'b0;
    end
  end

  // Timer state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= 32'd0;
      compare_q <= 32'd0;
      pend_q    <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      pend_q    <= pend_d;
    end
  end

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt controller: holds SR, Cause and EPC, arbitrates
// M-stage exceptions against hardware interrupts and raises the redirect
// request. Optional feature macro: CP0_TIMER_EN adds Count/Compare and ORs
// the timer interrupt into IP[7].
module cp0_exc_ctrl
  import cp0_exc_ctrl_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  cp0_exc_ctrl_if.slave  bus
);

  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [31:0] epc_q, epc_d;

  logic [5:0]  ip_next;
  logic        int_req;
  logic        exc_req;
  logic        take;
  logic        wr_en;
  logic        timer_irq;
  logic [31:0] rdata_c;

`ifdef CP0_TIMER_EN
  logic [31:0] count;
  logic [31:0] compare;

  cp0_timer u_timer (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .addr      (bus.addr),
    .wdata     (bus.wdata),
    .count     (count),
    .compare   (compare),
    .timer_irq (timer_irq)
  );
`else
  assign timer_irq = 1'b0;
`endif

  // The faulting instruction must not commit, so a redirect suppresses mtc0.
  assign ip_next = {bus.hw_int[5] | timer_irq, bus.hw_int[4:0]};
  assign int_req = (|(ip_next & im_q)) & ie_q & ~exl_q;
  assign exc_req = (bus.m_exc_code != 5'd0) & ~exl_q;
  assign take    = int_req | exc_req;
  assign wr_en   = bus.we & ~take;

  assign bus.req     = take & ~reset;
  assign bus.epc_out = (bus.we && bus.addr == CP0_EPC) ? bus.wdata : epc_q;
  assign bus.rdata   = rdata_c;

  // mfc0 read mux; unimplemented registers read as zero.
  always_comb begin
    rdata_c = 32'd0;
    case (bus.addr)
      CP0_SR:    rdata_c = {16'd0, im_q, 8'd0, exl_q, ie_q};
      CP0_CAUSE: rdata_c = {bd_q, 15'd0, ip_q, 3'd0, exc_code_q, 2'd0};
      CP0_EPC:   rdata_c = epc_q;
`ifdef CP0_TIMER_EN
      CP0_COUNT:   rdata_c = count;
      CP0_COMPARE: rdata_c = compare;
`endif
      default:   rdata_c = 32'd0;
    endcase
  end

  // Next-state: IP sampling, mtc0, eret, then exception entry (highest priority).
  always_comb begin
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    ip_d       = ip_next;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
    if (wr_en && bus.addr == CP0_SR) begin
      im_d  = bus.wdata[15:10];
      exl_d = bus.wdata[1];
      ie_d  = bus.wdata[0];
    end
    if (wr_en && bus.addr == CP0_EPC) begin
      epc_d = bus.wdata;
    end
    if (bus.m_eret && !take) begin
      exl_d = 1'b0;
    end
    if (take) begin
      exl_d      = 1'b1;
      bd_d       = bus.m_bd;
      exc_code_d = int_req ? EXC_INT : bus.m_exc_code;
      epc_d      = bus.m_bd ? (bus.m_pc - 32'd4) : bus.m_pc;
    end
  end

  // CP0 state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      im_q       <= 6'd0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ip_q       <= 6'd0;
      exc_code_q <= 5'd0;
      epc_q      <= 32'd0;
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ip_q       <= ip_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
    end
  end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Scoreboard bench for cp0_exc_ctrl: a word-level model predicts req,
// epc_out and rdata for each driven cycle; a monitor compares them.
module tb_cp0_exc_ctrl;
  import cp0_exc_ctrl_pkg::*;

  typedef struct {
    logic        rst;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic        bd;
    logic [4:0]  code;
    logic        eret;
    logic [5:0]  hw_int;
  } stim_t;

  typedef struct {
    logic        req;
    logic [31:0] epc_out;
    logic [31:0] rdata;
    logic [4:0]  addr;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  cp0_exc_ctrl_if bus();

  cp0_exc_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  logic [31:0] m_sr, m_cause, m_epc;
  bit          model_known = 0;
`ifdef CP0_TIMER_EN
  logic [31:0] m_count, m_compare;
  logic        m_pend;
`endif

  // Register contents as software would see them through mfc0.
  function automatic logic [31:0] modelRead(input logic [4:0] a);
    logic [31:0] v;
    v = 32'd0;
    if (a == 5'd12) v = m_sr;
    if (a == 5'd13) v = m_cause;
    if (a == 5'd14) v = m_epc;
`ifdef CP0_TIMER_EN
    if (a == 5'd9)  v = m_count;
    if (a == 5'd11) v = m_compare;
`endif
    return v;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s.rst = 1'b0; s.we = 1'b0; s.addr = CP0_SR; s.wdata = 32'd0;
    s.pc = 32'h0000_3000; s.bd = 1'b0; s.code = 5'd0; s.eret = 1'b0;
    s.hw_int = 6'd0;
    return s;
  endfunction

  // Drive one cycle, push the predicted outputs, then advance the model.
  task automatic applyStimulus(input stim_t s);
    logic [5:0]  ip;
    logic        tmr, intr, exc, rq;
    exp_t        e;
    @(posedge clk);
    #1;
    reset          = s.rst;
    bus.we         = s.we;
    bus.addr       = s.addr;
    bus.wdata      = s.wdata;
    bus.m_pc       = s.pc;
    bus.m_bd       = s.bd;
    bus.m_exc_code = s.code;
    bus.m_eret     = s.eret;
    bus.hw_int     = s.hw_int;
    tmr = 1'b0;
`ifdef CP0_TIMER_EN
    tmr = m_pend || (m_count == m_compare && m_compare != 32'd0);
`endif
    ip = s.hw_int;
    ip[5] = ip[5] | tmr;
    intr = ((ip & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
    exc  = (s.code != 5'd0) && !m_sr[1];
    rq   = (intr || exc) && !s.rst;
    if (model_known) begin
      e.req     = rq;
      e.epc_out = (s.we && s.addr == 5'd14) ? s.wdata : m_epc;
      e.rdata   = modelRead(s.addr);
      e.addr    = s.addr;
      exp_q.push_back(e);
    end
    if (s.rst) begin
      m_sr = 32'd0; m_cause = 32'd0; m_epc = 32'd0;
`ifdef CP0_TIMER_EN
      m_count = 32'd0; m_compare = 32'd0; m_pend = 1'b0;
`endif
      model_known = 1;
    end else begin
`ifdef CP0_TIMER_EN
      m_pend = m_pend || (m_count == m_compare && m_compare != 32'd0);
      m_count = m_count + 32'd1;
      if (s.we && !rq && s.addr == 5'd9) m_count = s.wdata;
      if (s.we && !rq && s.addr == 5'd11) begin
        m_compare = s.wdata;
        m_pend = 1'b0;
      end
`endif
      m_cause[15:10] = ip;
      if (rq) begin
        m_sr[1]       = 1'b1;
        m_cause[31]   = s.bd;
        m_cause[6:2]  = intr ? 5'd0 : s.code;
        m_epc         = s.bd ? s.pc - 32'd4 : s.pc;
      end else begin
        if (s.we && s.addr == 5'd12) m_sr = s.wdata & SR_WMASK;
        if (s.we && s.addr == 5'd14) m_epc = s.wdata;
        if (s.eret) m_sr[1] = 1'b0;
      end
    end
  endtask

  task automatic checkOutput(input exp_t e);
    n_vec++;
    if (bus.req !== e.req) begin
      n_miss++;
      $display("[TB] FAIL req: got %b expected %b at %0t", bus.req, e.req, $time);
    end
    n_vec++;
    if (bus.epc_out !== e.epc_out) begin
      n_miss++;
      $display("[TB] FAIL epc_out: got %h expected %h at %0t", bus.epc_out, e.epc_out, $time);
    end
    n_vec++;
    if (bus.rdata !== e.rdata) begin
      n_miss++;
      $display("[TB] FAIL rdata[%0d]: got %h expected %h at %0t", e.addr, bus.rdata, e.rdata, $time);
    end
  endtask

  // Monitor: compare DUT outputs mid-cycle against the oldest prediction.
  always @(negedge clk) begin
    if (exp_q.size() != 0) checkOutput(exp_q.pop_front());
  end

  initial begin
    stim_t s;
    reset = 1'b1;
    bus.we = 1'b0; bus.addr = 5'd0; bus.wdata = 32'd0; bus.m_pc = 32'd0;
    bus.m_bd = 1'b0; bus.m_exc_code = 5'd0; bus.m_eret = 1'b0; bus.hw_int = 6'd0;
    $display("[TB] handler entry %h", EXC_ENTRY);

    s = idle(); s.rst = 1'b1; applyStimulus(s); s.addr = CP0_CAUSE; applyStimulus(s);

    // Overflow exception outside a delay slot.
    s = idle(); s.code = EXC_OV; s.pc = 32'h0000_3010; s.addr = CP0_CAUSE; applyStimulus(s);
    s = idle(); s.addr = CP0_CAUSE; applyStimulus(s);
    s.addr = CP0_EPC; applyStimulus(s);
    s.addr = CP0_SR; applyStimulus(s);
    s = idle(); s.eret = 1'b1; applyStimulus(s);

    // Reserved instruction in a delay slot.
    s = idle(); s.code = EXC_RI; s.bd = 1'b1; s.pc = 32'h0000_3024; applyStimulus(s);
    s = idle(); s.addr = CP0_EPC; applyStimulus(s);
    s.addr = CP0_CAUSE; applyStimulus(s);
    s = idle(); s.eret = 1'b1; applyStimulus(s);

    // Interrupt gating by IE.
    s = idle(); s.we = 1'b1; s.wdata = 32'h0000_0401; applyStimulus(s);
    s = idle(); s.hw_int = 6'b000001; applyStimulus(s);
    s = idle(); s.addr = CP0_CAUSE; applyStimulus(s);
    s = idle(); s.eret = 1'b1; applyStimulus(s);
    s = idle(); s.we = 1'b1; s.wdata = 32'h0000_0400; applyStimulus(s);
    s = idle(); s.hw_int = 6'b000001; applyStimulus(s);
    s.addr = CP0_CAUSE; applyStimulus(s);

    // Interrupt beats exception; exception suppresses a same-cycle mtc0.
    s = idle(); s.we = 1'b1; s.wdata = 32'h0000_0401; applyStimulus(s);
    s = idle(); s.hw_int = 6'b000001; s.code = EXC_ADEL; applyStimulus(s);
    s = idle(); s.addr = CP0_CAUSE; applyStimulus(s);
    s = idle(); s.eret = 1'b1; applyStimulus(s);
    s = idle(); s.we = 1'b1; s.wdata = 32'd0; s.code = EXC_SYSCALL; applyStimulus(s);
    s = idle(); applyStimulus(s);

    // Nested exception masked, then mtc0 EPC with eret bypass.
    s = idle(); s.code = EXC_OV; s.pc = 32'h0000_3200; s.addr = CP0_EPC; applyStimulus(s);
    s = idle(); s.we = 1'b1; s.addr = CP0_EPC; s.wdata = 32'h0000_3100; s.eret = 1'b1; applyStimulus(s);
    s = idle(); applyStimulus(s);

    // Reset in the middle of a handler.
    s = idle(); s.code = EXC_SYSCALL; applyStimulus(s);
    s = idle(); s.rst = 1'b1; applyStimulus(s);
    s = idle(); s.code = EXC_ADES; s.pc = 32'h0000_3300; applyStimulus(s);
    s = idle(); s.addr = CP0_CAUSE; s.eret = 1'b1; applyStimulus(s);

`ifdef CP0_TIMER_EN
    // Timer interrupt at Count == Compare, then Compare clear and Count wrap.
    s = idle(); s.we = 1'b1; s.wdata = 32'h0000_8001; applyStimulus(s);
    s.addr = CP0_COMPARE; s.wdata = 32'd5; applyStimulus(s);
    s.addr = CP0_COUNT; s.wdata = 32'd0; applyStimulus(s);
    for (int i = 0; i < 8; i++) begin
      s = idle(); s.addr = CP0_COUNT; applyStimulus(s);
    end
    s = idle(); s.we = 1'b1; s.addr = CP0_COMPARE; s.wdata = 32'd0; s.eret = 1'b1; applyStimulus(s);
    s = idle(); s.we = 1'b1; s.addr = CP0_COUNT; s.wdata = 32'hFFFF_FFFF; applyStimulus(s);
    s = idle(); s.addr = CP0_COUNT; applyStimulus(s);
    applyStimulus(s);
`endif

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      int k;
      s = idle();
      s.rst = ($urandom_range(0, 99) < 2);
      s.we  = ($urandom_range(0, 99) < 30);
      k = $urandom_range(0, 7);
      case (k)
        0: s.addr = CP0_COUNT;
        1: s.addr = CP0_COMPARE;
        2, 3: s.addr = CP0_SR;
        4: s.addr = CP0_CAUSE;
        5: s.addr = CP0_EPC;
        default: s.addr = 5'($urandom_range(0, 31));
      endcase
      s.wdata = $urandom;
      if (s.addr == CP0_SR && $urandom_range(0, 1) == 1) s.wdata[1] = 1'b0;
      if (s.addr == CP0_COUNT) s.wdata = $urandom_range(0, 20);
      if (s.addr == CP0_COMPARE) s.wdata = $urandom_range(0, 40);
      s.pc = $urandom & 32'hFFFF_FFFC;
      s.bd = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 99) < 25) begin
        k = $urandom_range(0, 5);
        case (k)
          0: s.code = EXC_ADEL;
          1: s.code = EXC_ADES;
          2: s.code = EXC_SYSCALL;
          3: s.code = EXC_RI;
          4: s.code = EXC_OV;
          default: s.code = 5'($urandom_range(1, 31));
        endcase
      end
      s.eret = ($urandom_range(0, 99) < 15);
      if ($urandom_range(0, 99) < 40) s.hw_int = 6'($urandom_range(1, 63));
      applyStimulus(s);
    end

    repeat (2) @(negedge clk);
    #1;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/cp0_exc_ctrl.md
# cp0_exc_ctrl

Coprocessor-0 exception/interrupt controller for the five-stage MIPS pipeline. It holds SR, Cause and EPC, and arbitrates M-stage exceptions against external hardware interrupts. It raises the single-cycle redirect request `req` consumed by the next-PC logic (target 0x0000_4180), and supplies the return address used on `eret`. It sits beside the M stage and is the only block allowed to set or clear EXL.

## Interface
Parameters:
- `EXC_ENTRY`, 32'h0000_4180, handler address, exported for the NPC mux and the bench.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `we`  in  1  mtc0 write enable (M stage).
- `addr`  in  5  CP0 register number for mtc0/mfc0.
- `wdata`  in  32  mtc0 data.
- `rdata`  out  32  mfc0 data, combinational from `addr`.
- `m_pc`  in  32  PC of the instruction in M.
- `m_bd`  in  1  M instruction sits in a delay slot.
- `m_exc_code`  in  5  pending synchronous exception code; 0 means none.
- `m_eret`  in  1  eret in M.
- `hw_int`  in  6  external interrupt lines, mapped to IP[7:2].
- `req`  out  1  take-exception redirect; flushes F–M.
- `epc_out`  out  32  EPC to NPC, with mtc0 bypass.

## Operation
- SR (12): IM = [15:10], EXL = [1], IE = [0]. Other bits read 0 and ignore writes.
- Cause (13): BD = [31], IP = [15:10], ExcCode = [6:2]. Read-only to mtc0; writes are ignored.
- EPC (14): full 32 bits, writable by mtc0.
- `int_req` = |(IP_next & IM) & IE & ~EXL, where IP_next is the current `hw_int` (plus the timer bit).
- `exc_req` = (m_exc_code != 0) & ~EXL.
- `req` = (int_req | exc_req) & ~reset. Combinational, same cycle as the M instruction.
- Priority: interrupt beats a synchronous exception in the same cycle, so the recorded ExcCode is 0 (Int).
- On an edge with `req`=1:
  - EXL <= 1.
  - BD <= m_bd.
  - ExcCode <= int_req ? 0 : m_exc_code.
  - EPC <= m_bd ? m_pc − 4 : m_pc, with 32-bit wrapping subtract.
- IP is sampled from `hw_int` every cycle, regardless of EXL.
- `req` and `we` in the same cycle: the mtc0 is suppressed, because the faulting instruction must not commit.
- `m_eret` with `req`=0: EXL <= 0 at the edge. `m_eret` with `req`=1 cannot change EXL in a legal program; if it occurs, `req` wins.
- `epc_out` = (we && addr==14) ? wdata : EPC, so an mtc0 immediately followed by eret returns to the new value.
- mfc0 of an unimplemented address returns 0.

## Timing
- Reset: SR, Cause, EPC (and Count/Compare when configured) are 0. `req`=0 and `rdata` reflects the zeroed registers.
- Reset asserted mid-handler clears EXL; the next cycle accepts requests normally.
- Latency: `req` is asserted in the same cycle as the offending M instruction. CP0 state is visible via `rdata` from the next cycle.
- mtc0 takes effect at the edge. An `int_req` in the cycle after an SR write uses the new IM/IE.
- Nested events while EXL=1 are masked and cause no state change except IP sampling.

## Configuration
- `CP0_TIMER_EN` defined:
  - Adds Count (9) and Compare (11).
  - Count increments each cycle and wraps 0xFFFF_FFFF→0; an mtc0 to Count overrides the increment that cycle.
  - When Count == Compare and Compare != 0, a sticky timer pending bit sets and is ORed into IP[7].
  - Writing Compare clears the sticky bit.
- Undefined: Count/Compare are absent, reads of 9/11 return 0, and IP[7] = hw_int[5] only.

## Structure
- Shared package holds:
  - CP0 register numbers (9, 11, 12, 13, 14).
  - ExcCode constants: Int=0, AdEL=4, AdES=5, Syscall=8, RI=10, Ov=12.
  - `EXC_ENTRY`.
- One sub-module, `cp0_timer`, holds Count/Compare and the sticky pending bit. It is instantiated only under `CP0_TIMER_EN`.

## Test plan
- Ov exception: `m_exc_code`=12, `m_pc`=0x3010, `m_bd`=0, EXL=0. Expect `req`=1 that cycle; next cycle Cause.ExcCode=12, EPC=0x3010, SR.EXL=1.
- Delay-slot exception: `m_bd`=1, `m_pc`=0x3024, code 10. Expect EPC=0x3020 and Cause[31]=1.
- Interrupt gating: SR=0x0000_0401, `hw_int`=6'b000001. Expect `req`=1 and ExcCode=0. Repeat with IE=0: `req`=0, while Cause IP[10] still reads 1.
- Interrupt plus exception in the same cycle, with code 4. Expect ExcCode=0. In a second case (no interrupt), issue simultaneous mtc0 to SR with wdata=0. Expect SR unchanged.
- eret bypass: with EXL=1, mtc0 EPC=0x3100 and `m_eret` in the same cycle. Expect `epc_out`=0x3100 that cycle and EXL=0 next cycle. A second exception while EXL=1 yields `req`=0.
- `CP0_TIMER_EN`: Compare=5, IM[7]=1, IE=1. Expect `req` asserted at Count=5. Writing Compare clears the pending bit; Count preloaded to 0xFFFF_FFFF reads 0 one cycle later.
